// File: rtl/unibus_parmem_if.sv
// Unibus slave-side signal bundle for unibus_parmem: address, control, data and the
// MSYN/SSYN handshake.
interface unibus_parmem_if;
  logic [17:0] a_in_h;
  logic [1:0]  c_in_h;
  logic [15:0] d_in_h;
  logic        init_in_h;
  logic        msyn_in_h;
  logic [15:0] d_out_h;
  logic        ssyn_out_h;

  modport master (
    output a_in_h, c_in_h, d_in_h, init_in_h, msyn_in_h,
    input  d_out_h, ssyn_out_h
  );

  modport slave (
    input  a_in_h, c_in_h, d_in_h, init_in_h, msyn_in_h,
    output d_out_h, ssyn_out_h
  );
endinterface

// File: rtl/unibus_parmem.sv
// Parametrised Unibus main-memory slave over an external 18-bit parity RAM, with an
// ARM register port sharing the RAM through round-robin arbitration.
module unibus_parmem #(
  parameter int unsigned NPAGES = 62,
  parameter int unsigned MEMLAT = 2
) (
  input  logic           CLOCK,
  input  logic           RESET,
  input  logic           armwrite,
  input  logic [2:0]     armraddr,
  input  logic [2:0]     armwaddr,
  input  logic [31:0]    armwdata,
  output logic [31:0]    armrdata,
  unibus_parmem_if.slave ub,
  output logic [16:0]    extmemaddr,
  output logic [17:0]    extmemdout,
  input  logic [17:0]    extmemdin,
  output logic           extmemenab,
  output logic [1:0]     extmemwena,
  output logic           parerr_out
);
  localparam logic [63:0] PageMask = (NPAGES >= 64) ? {64{1'b1}} :
                                     ((64'd1 << NPAGES) - 64'd1);
  localparam logic [2:0]  LatCnt   = 3'(MEMLAT);
  localparam logic [31:0] IdWord   = 32'h424D_2010;

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StWaitMsyn} state_e;

  state_e      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic        gnt_arm_q, gnt_arm_d;
  logic        last_arm_q, last_arm_d;
  logic [63:0] enable_q, enable_d;
  logic [2:0]  armfunc_q, armfunc_d;
  logic        autoinc_q, autoinc_d;
  logic [17:0] armaddr_q, armaddr_d;
  logic [15:0] armdata_q, armdata_d;
  logic        armpehi_q, armpehi_d;
  logic        armpelo_q, armpelo_d;
  logic        errv_q, errv_d;
  logic        overrun_q, overrun_d;
  logic [17:0] erraddr_q, erraddr_d;
  logic        pchk_q, pchk_d;
  logic        pwith_q, pwith_d;
  logic [15:0] errcnt_q, errcnt_d;
  logic [17:0] cur_addr_q, cur_addr_d;
  logic        cur_dati_q, cur_dati_d;
  logic [16:0] memaddr_q, memaddr_d;
  logic [17:0] memdout_q, memdout_d;
  logic        memenab_q, memenab_d;
  logic [1:0]  memwena_q, memwena_d;
  logic [15:0] dout_q, dout_d;
  logic        ssyn_q, ssyn_d;

  logic        busy, arm_req, ub_req, grant_arm, fail_hi, fail_lo, ub_pe;
  logic [1:0]  ub_wena;
  logic [17:0] ub_wdata, arm_wdata;

  assign busy      = (armfunc_q != 3'd0) |
                     (gnt_arm_q & (state_q == StAccess || state_q == StDone));
  assign arm_req   = armfunc_q != 3'd0;
  // Enable bits beyond NPAGES are never set, so the page range check is implicit.
  assign ub_req    = ub.msyn_in_h & enable_q[ub.a_in_h[17:12]];
  assign grant_arm = arm_req & (~ub_req | ~last_arm_q);
  assign ub_wena   = ub.c_in_h[1] ? (ub.c_in_h[0] ? {ub.a_in_h[0], ~ub.a_in_h[0]} : 2'b11)
                                  : 2'b00;
  assign ub_wdata  = {~^ub.d_in_h[15:8], ub.d_in_h[15:8], ~^ub.d_in_h[7:0], ub.d_in_h[7:0]};
  assign arm_wdata = {~^armdata_q[15:8] ^ armpehi_q, armdata_q[15:8],
                      ~^armdata_q[7:0] ^ armpelo_q, armdata_q[7:0]};
  assign fail_hi   = ~^extmemdin[17:9];
  assign fail_lo   = ~^extmemdin[8:0];
  assign ub_pe     = cur_dati_q & pchk_q & (fail_hi | fail_lo);

  always_comb begin
    armrdata = '0;
    case (armraddr)
      3'd0: armrdata = IdWord;
      3'd1: armrdata = enable_q[31:0];
      3'd2: armrdata = enable_q[63:32];
      3'd3: armrdata = {armfunc_q, autoinc_q, 10'd0, armaddr_q};
      3'd4: armrdata = {busy, 13'd0, armpehi_q, armpelo_q, armdata_q};
      3'd5: armrdata = {errv_q, overrun_q, 12'd0, erraddr_q};
      3'd6: armrdata = {30'd0, pwith_q, pchk_q};
      3'd7: armrdata = {16'd0, errcnt_q};
      default: armrdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    gnt_arm_d  = gnt_arm_q;
    last_arm_d = last_arm_q;
    enable_d   = enable_q;
    armfunc_d  = armfunc_q;
    autoinc_d  = autoinc_q;
    armaddr_d  = armaddr_q;
    armdata_d  = armdata_q;
    armpehi_d  = armpehi_q;
    armpelo_d  = armpelo_q;
    errv_d     = errv_q;
    overrun_d  = overrun_q;
    erraddr_d  = erraddr_q;
    pchk_d     = pchk_q;
    pwith_d    = pwith_q;
    errcnt_d   = errcnt_q;
    cur_addr_d = cur_addr_q;
    cur_dati_d = cur_dati_q;
    memaddr_d  = memaddr_q;
    memdout_d  = memdout_q;
    memenab_d  = memenab_q;
    memwena_d  = memwena_q;
    dout_d     = dout_q;
    ssyn_d     = ssyn_q;

    if (armwrite) begin
      case (armwaddr)
        3'd1: enable_d[31:0]  = armwdata & PageMask[31:0];
        3'd2: enable_d[63:32] = armwdata & PageMask[63:32];
        3'd3: if (!busy) begin
          armfunc_d = armwdata[31:29];
          autoinc_d = armwdata[28];
          armaddr_d = armwdata[17:0];
        end
        3'd4: if (!busy) begin
          armpehi_d = armwdata[17];
          armpelo_d = armwdata[16];
          armdata_d = armwdata[15:0];
        end
        3'd5: if (armwdata[31]) begin
          errv_d    = 1'b0;
          overrun_d = 1'b0;
          erraddr_d = '0;
        end
        3'd6: {pwith_d, pchk_d} = armwdata[1:0];
        3'd7: errcnt_d = '0;
        default: ;
      endcase
    end

    // FSM updates come after register writes so they win on armfunc/armaddr.
    if (ub.init_in_h) begin
      state_d   = StIdle;
      ssyn_d    = 1'b0;
      dout_d    = '0;
      memenab_d = 1'b0;
      memwena_d = 2'b00;
    end else begin
      case (state_q)
        StIdle: begin
          if (arm_req || ub_req) begin
            state_d    = StAccess;
            lat_d      = 3'd1;
            memenab_d  = 1'b1;
            gnt_arm_d  = grant_arm;
            last_arm_d = grant_arm;
            if (grant_arm) begin
              memaddr_d = armaddr_q[17:1];
              memwena_d = armfunc_q[1:0];
              memdout_d = arm_wdata;
            end else begin
              memaddr_d  = ub.a_in_h[17:1];
              memwena_d  = ub_wena;
              memdout_d  = ub_wdata;
              cur_addr_d = ub.a_in_h;
              cur_dati_d = ~ub.c_in_h[1];
            end
          end
        end
        StAccess: begin
          if (lat_q == LatCnt) state_d = StDone;
          else lat_d = lat_q + 3'd1;
        end
        StDone: begin
          memenab_d = 1'b0;
          memwena_d = 2'b00;
          if (gnt_arm_q) begin
            if (armfunc_q == 3'd4) begin
              armdata_d = {extmemdin[16:9], extmemdin[7:0]};
              armpehi_d = fail_hi;
              armpelo_d = fail_lo;
            end
            armfunc_d = 3'd0;
            if (autoinc_q) armaddr_d = armaddr_q + 18'd2;
            state_d = StIdle;
          end else begin
            if (ub_pe) begin
              if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
              if (!errv_q) begin
                errv_d    = 1'b1;
                erraddr_d = cur_addr_q;
              end else begin
                overrun_d = 1'b1;
              end
            end
            // A withheld SSYN lets the bus master time out and trap.
            if (!(ub_pe && pwith_q)) begin
              ssyn_d = 1'b1;
              if (cur_dati_q) dout_d = {extmemdin[16:9], extmemdin[7:0]};
            end
            state_d = StWaitMsyn;
          end
        end
        StWaitMsyn: begin
          if (!ub.msyn_in_h) begin
            ssyn_d  = 1'b0;
            dout_d  = '0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= StIdle;
      lat_q      <= '0;
      gnt_arm_q  <= 1'b0;
      last_arm_q <= 1'b0;
      enable_q   <= '0;
      armfunc_q  <= '0;
      autoinc_q  <= 1'b0;
      armaddr_q  <= '0;
      armdata_q  <= '0;
      armpehi_q  <= 1'b0;
      armpelo_q  <= 1'b0;
      errv_q     <= 1'b0;
      overrun_q  <= 1'b0;
      erraddr_q  <= '0;
      pchk_q     <= 1'b0;
      pwith_q    <= 1'b0;
      errcnt_q   <= '0;
      cur_addr_q <= '0;
      cur_dati_q <= 1'b0;
      memaddr_q  <= '0;
      memdout_q  <= '0;
      memenab_q  <= 1'b0;
      memwena_q  <= 2'b00;
      dout_q     <= '0;
      ssyn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      gnt_arm_q  <= gnt_arm_d;
      last_arm_q <= last_arm_d;
      enable_q   <= enable_d;
      armfunc_q  <= armfunc_d;
      autoinc_q  <= autoinc_d;
      armaddr_q  <= armaddr_d;
      armdata_q  <= armdata_d;
      armpehi_q  <= armpehi_d;
      armpelo_q  <= armpelo_d;
      errv_q     <= errv_d;
      overrun_q  <= overrun_d;
      erraddr_q  <= erraddr_d;
      pchk_q     <= pchk_d;
      pwith_q    <= pwith_d;
      errcnt_q   <= errcnt_d;
      cur_addr_q <= cur_addr_d;
      cur_dati_q <= cur_dati_d;
      memaddr_q  <= memaddr_d;
      memdout_q  <= memdout_d;
      memenab_q  <= memenab_d;
      memwena_q  <= memwena_d;
      dout_q     <= dout_d;
      ssyn_q     <= ssyn_d;
    end
  end

  assign extmemaddr    = memaddr_q;
  assign extmemdout    = memdout_q;
  assign extmemenab    = memenab_q;
  assign extmemwena    = memwena_q;
  assign ub.d_out_h    = dout_q;
  assign ub.ssyn_out_h = ssyn_q;
  assign parerr_out    = errv_q;
endmodule

// File: tb/tb_unibus_parmem.sv
// Directed testbench for unibus_parmem (NPAGES = 62, MEMLAT = 2) with a behavioural
// 128K x 18 RAM.
module tb_unibus_parmem;
  logic        clk, rst;
  logic        armwrite;
  logic [2:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [16:0] extmemaddr;
  logic [17:0] extmemdout, extmemdin;
  logic        extmemenab, parerr_out;
  logic [1:0]  extmemwena;
  int tests_run, tests_failed;

  unibus_parmem_if ub ();

  unibus_parmem #(.NPAGES(62), .MEMLAT(2)) dut (
    .CLOCK(clk), .RESET(rst), .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata), .ub(ub), .extmemaddr(extmemaddr),
    .extmemdout(extmemdout), .extmemdin(extmemdin), .extmemenab(extmemenab),
    .extmemwena(extmemwena), .parerr_out(parerr_out)
  );

  always #5 clk = ~clk;

  // Parity bits are stored inverted so a cleared word reads back as zero with good parity.
  logic [17:0] mem [0:131071];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 131072; i++) mem[i] <= '0;
    end else if (extmemenab) begin
      if (extmemwena[1]) mem[extmemaddr][17:9] <= extmemdout[17:9] ^ 9'h100;
      if (extmemwena[0]) mem[extmemaddr][8:0]  <= extmemdout[8:0] ^ 9'h100;
    end
  end
  assign extmemdin = mem[extmemaddr] ^ 18'h20100;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
    armwaddr = a; armwdata = d; armwrite = 1'b1;
    tick(1);
    armwrite = 1'b0;
  endtask

  task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
    armraddr = a;
    #1;
    d = armrdata;
  endtask

  task automatic wait_idle(output int n);
    logic [31:0] r;
    n = 0;
    do begin
      tick(1); n++;
      arm_rd(3'd4, r);
    end while (r[31] && n < 30);
    tests_run++;
    if (r[31]) begin
      tests_failed++; $display("FAIL arm_busy_timeout: busy=%b after %0d cycles, want 0", r[31], n);
    end
  endtask

  task automatic ub_cycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                          output logic got, output logic [15:0] rd, output int lat,
                          output logic [1:0] wena, output logic fell);
    got = 1'b0; rd = '0; lat = 0; wena = 2'b00;
    ub.a_in_h = a; ub.c_in_h = c; ub.d_in_h = d; ub.msyn_in_h = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      tick(1); lat++;
      if (extmemenab && wena == 2'b00) wena = extmemwena;
      if (ub.ssyn_out_h) got = 1'b1;
      rd = ub.d_out_h;
    end
    ub.msyn_in_h = 1'b0;
    tick(1);
    fell = !ub.ssyn_out_h;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    tests_run++;
    if ({ub.ssyn_out_h, ub.d_out_h, extmemenab, extmemwena, parerr_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ssyn=%b dout=%h enab=%b wena=%b perr=%b want all 0",
               ub.ssyn_out_h, ub.d_out_h, extmemenab, extmemwena, parerr_out);
    end
    for (int i = 0; i < 8; i++) begin
      arm_rd(3'(i), r);
      tests_run++;
      if (r !== ((i == 0) ? 32'h424D_2010 : 32'h0)) begin
        tests_failed++; $display("FAIL reset_reg%0d: got %h want %h", i, r,
                                 (i == 0) ? 32'h424D_2010 : 32'h0);
      end
      tick(1);
    end
  endtask

  task automatic test_dato_dati();
    logic got, fell; logic [15:0] rd; int lat; logic [1:0] w;
    arm_wr(3'd1, 32'h1);
    ub_cycle(18'o000100, 2'b10, 16'o012345, got, rd, lat, w, fell);
    tests_run++;
    if (!got || lat != 4 || w !== 2'b11) begin
      tests_failed++; $display("FAIL dato: ssyn=%b lat=%0d wena=%b want 1/4/11", got, lat, w);
    end
    ub_cycle(18'o000100, 2'b00, 16'h0, got, rd, lat, w, fell);
    tests_run++;
    if (!got || rd !== 16'o012345 || lat != 4) begin
      tests_failed++;
      $display("FAIL dati: ssyn=%b data=%o lat=%0d want 1/012345/4", got, rd, lat);
    end
    tests_run++;
    if (!fell) begin
      tests_failed++; $display("FAIL ssyn_fall: ssyn still %b one clock after MSYN low, want 0",
                               ub.ssyn_out_h);
    end
  endtask

  task automatic test_datob();
    logic got, fell; logic [15:0] rd; int lat; logic [1:0] w;
    ub_cycle(18'o000101, 2'b11, 16'o177400, got, rd, lat, w, fell);
    tests_run++;
    if (!got || w !== 2'b10) begin
      tests_failed++; $display("FAIL datob_wena: ssyn=%b wena=%b want 1/10", got, w);
    end
    ub_cycle(18'o000100, 2'b00, 16'h0, got, rd, lat, w, fell);
    tests_run++;
    if (!got || rd !== 16'hFFE5) begin
      tests_failed++; $display("FAIL datob_readback: ssyn=%b data=%h want 1/ffe5", got, rd);
    end
  endtask

  task automatic test_parity();
    logic got, fell; logic [15:0] rd; int lat, n; logic [1:0] w; logic [31:0] r;
    arm_wr(3'd4, 32'h0001_1234);
    arm_wr(3'd3, 32'h6000_0080);
    wait_idle(n);
    tests_run++;
    if (n != 4) begin
      tests_failed++; $display("FAIL arm_latency: got %0d cycles want 4", n);
    end
    arm_wr(3'd4, 32'h0);
    arm_wr(3'd3, 32'h8000_0080);
    wait_idle(n);
    arm_rd(3'd4, r);
    tests_run++;
    if (r !== 32'h0001_1234) begin
      tests_failed++; $display("FAIL arm_read_pe: got %h want 00011234", r);
    end
    arm_wr(3'd6, 32'h3);
    ub_cycle(18'o000200, 2'b00, 16'h0, got, rd, lat, w, fell);
    tests_run++;
    if (got || rd !== 16'h0 || parerr_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL pe_withhold: ssyn=%b data=%h perr=%b want 0/0000/1", got, rd, parerr_out);
    end
    arm_rd(3'd5, r);
    tests_run++;
    if (r !== 32'h8000_0080) begin
      tests_failed++; $display("FAIL pe_log: reg5=%h want 80000080", r);
    end
    arm_rd(3'd7, r);
    tests_run++;
    if (r !== 32'h1) begin
      tests_failed++; $display("FAIL pe_count1: reg7=%h want 1", r);
    end
    tick(1);
    ub_cycle(18'o000200, 2'b00, 16'h0, got, rd, lat, w, fell);
    arm_rd(3'd5, r);
    tests_run++;
    if (r !== 32'hC000_0080) begin
      tests_failed++; $display("FAIL pe_overrun: reg5=%h want c0000080", r);
    end
    tick(1);
    arm_wr(3'd6, 32'h1);
    ub_cycle(18'o000200, 2'b00, 16'h0, got, rd, lat, w, fell);
    arm_rd(3'd7, r);
    tests_run++;
    if (!got || rd !== 16'h1234 || r !== 32'h3) begin
      tests_failed++;
      $display("FAIL pe_no_withhold: ssyn=%b data=%h cnt=%h want 1/1234/3", got, rd, r);
    end
    tick(1);
    arm_wr(3'd5, 32'h8000_0000);
    arm_wr(3'd7, 32'h0);
    arm_wr(3'd6, 32'h0);
    arm_rd(3'd5, r);
    tests_run++;
    if (r !== 32'h0 || parerr_out !== 1'b0) begin
      tests_failed++; $display("FAIL pe_clear: reg5=%h perr=%b want 0/0", r, parerr_out);
    end
    tick(1);
  endtask

  task automatic test_pages();
    logic got, fell; logic [15:0] rd; int lat; logic [1:0] w; logic [31:0] r;
    arm_wr(3'd2, 32'hFFFF_FFFF);
    arm_rd(3'd2, r);
    tests_run++;
    if (r !== 32'h3FFF_FFFF) begin
      tests_failed++; $display("FAIL enable_mask: reg2=%h want 3fffffff", r);
    end
    tick(1);
    arm_wr(3'd1, 32'h0);
    arm_wr(3'd2, 32'h2000_0000);
    ub_cycle(18'o760000, 2'b00, 16'h0, got, rd, lat, w, fell);
    tests_run++;
    if (got || w !== 2'b00) begin
      tests_failed++; $display("FAIL page62_ignored: ssyn=%b want 0", got);
    end
    ub_cycle(18'o000100, 2'b00, 16'h0, got, rd, lat, w, fell);
    tests_run++;
    if (got) begin
      tests_failed++; $display("FAIL page0_disabled: ssyn=%b want 0", got);
    end
    ub_cycle(18'o750000, 2'b00, 16'h0, got, rd, lat, w, fell);
    tests_run++;
    if (!got || rd !== 16'h0) begin
      tests_failed++; $display("FAIL page61_enabled: ssyn=%b data=%h want 1/0000", got, rd);
    end
  endtask

  task automatic test_arbitration();
    logic got; logic [15:0] rd; int n; logic [31:0] r;
    arm_wr(3'd1, 32'h1);
    arm_wr(3'd2, 32'h0);
    arm_wr(3'd3, 32'h8000_3000);
    ub.a_in_h = 18'o000100; ub.c_in_h = 2'b00; ub.msyn_in_h = 1'b1;
    tick(1);
    tests_run++;
    if (!extmemenab || extmemaddr !== 17'h1800) begin
      tests_failed++;
      $display("FAIL tie1_arm_first: enab=%b addr=%h want 1/01800", extmemenab, extmemaddr);
    end
    wait_idle(n);
    tests_run++;
    if (ub.ssyn_out_h !== 1'b0) begin
      tests_failed++; $display("FAIL tie1_order: ssyn=%b when ARM done, want 0", ub.ssyn_out_h);
    end
    got = 1'b0; rd = '0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick(1);
      got = ub.ssyn_out_h; rd = ub.d_out_h;
    end
    tests_run++;
    if (!got || rd !== 16'hFFE5) begin
      tests_failed++; $display("FAIL tie1_ub_second: ssyn=%b data=%h want 1/ffe5", got, rd);
    end
    ub.msyn_in_h = 1'b0;
    tick(1);
    arm_wr(3'd3, 32'h8000_3000);
    wait_idle(n);
    arm_wr(3'd3, 32'h8000_3000);
    ub.msyn_in_h = 1'b1;
    tick(1);
    tests_run++;
    if (!extmemenab || extmemaddr !== 17'h0020) begin
      tests_failed++;
      $display("FAIL tie2_ub_first: enab=%b addr=%h want 1/00020", extmemenab, extmemaddr);
    end
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick(1);
      got = ub.ssyn_out_h;
    end
    arm_rd(3'd4, r);
    tests_run++;
    if (!got || r[31] !== 1'b1) begin
      tests_failed++; $display("FAIL tie2_arm_waits: ssyn=%b busy=%b want 1/1", got, r[31]);
    end
    ub.msyn_in_h = 1'b0;
    tick(1);
    wait_idle(n);
  endtask

  task automatic test_autoinc_init();
    int n; logic [31:0] r;
    arm_wr(3'd3, 32'h9003_FFFE);
    wait_idle(n);
    arm_rd(3'd3, r);
    tests_run++;
    if (r !== 32'h1000_0000) begin
      tests_failed++; $display("FAIL autoinc_wrap: reg3=%h want 10000000", r);
    end
    tick(1);
    arm_wr(3'd4, 32'h0000_BEEF);
    arm_wr(3'd3, 32'h6000_0100);
    tick(1);
    ub.init_in_h = 1'b1;
    tick(1);
    tests_run++;
    if (extmemenab !== 1'b0 || extmemwena !== 2'b00) begin
      tests_failed++;
      $display("FAIL init_abort: enab=%b wena=%b want 0/00", extmemenab, extmemwena);
    end
    tick(2);
    arm_rd(3'd4, r);
    tests_run++;
    if (r[31] !== 1'b1) begin
      tests_failed++; $display("FAIL init_keeps_func: busy=%b want 1", r[31]);
    end
    ub.init_in_h = 1'b0;
    wait_idle(n);
    tests_run++;
    if (n != 4) begin
      tests_failed++; $display("FAIL init_reissue: busy cleared after %0d cycles want 4", n);
    end
    arm_wr(3'd4, 32'h0);
    arm_wr(3'd3, 32'h8000_0100);
    wait_idle(n);
    arm_rd(3'd4, r);
    tests_run++;
    if (r !== 32'h0000_BEEF) begin
      tests_failed++; $display("FAIL init_reissue_data: reg4=%h want 0000beef", r);
    end
    tick(1);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    clk = 1'b0; rst = 1'b1;
    armwrite = 1'b0; armraddr = '0; armwaddr = '0; armwdata = '0;
    ub.a_in_h = '0; ub.c_in_h = '0; ub.d_in_h = '0; ub.init_in_h = 1'b0; ub.msyn_in_h = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    test_reset();
    test_dato_dati();
    test_datob();
    test_parity();
    test_pages();
    test_arbitration();
    test_autoinc_init();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
